display_scan_ctrl: RTL and testbench
====================================

// Module: display_scan_ctrl
// PURPOSE
//   Scan scheduler for the dual seven-segment display multiplexer. Holds the
//   8-bit display value and time-slices two digits: enable[0] shows value[3:0],
//   enable[1] shows value[7:4], with a blanking gap between digits to kill ghosting.
//   New values enter via a valid/ready port and apply only at a frame boundary,
//   so a frame never shows a mix of old and new digits (no tearing).
// PARAMETERS
//   DWELL_CYCLES  25000  clk cycles each digit is lit (>=1)
//   BLANK_CYCLES  250    clk cycles both digits are dark between digits (0 = no gap)
// PORTS
//   clk        in   1  system clock; all logic on posedge clk
//   reset      in   1  synchronous, active-high reset
//   upd_valid  in   1  upd_value is offered this cycle
//   upd_value  in   8  new display value: [7:4] upper digit, [3:0] lower digit
//   upd_ready  out  1  ctrl can take a value (pending slot empty)
//   disp_en    in   1  0 = force enable to 2'b00; scanning keeps running
//   s          out  4  nibble to the segment decoder
//   enable     out  2  digit enables, one-hot or 2'b00 (never 2'b11)
//   frame_tick out  1  1-cycle pulse on the cycle a new frame starts
// BEHAVIOUR
//   - FSM states: SHOW0 -> BLANK0 -> SHOW1 -> BLANK1 -> SHOW0 ...
//     SHOWx lasts exactly DWELL_CYCLES, BLANKx exactly BLANK_CYCLES.
//     BLANK_CYCLES=0: BLANK states skipped (SHOW0 <-> SHOW1 directly).
//   - Frame period = 2*(DWELL_CYCLES+BLANK_CYCLES) cycles. The dwell counter is
//     sized $clog2(max(DWELL,BLANK)+1), clears on every state change, never wraps.
//   - All outputs registered. For SHOW0: enable=2'b01, s=shown[3:0];
//     SHOW1: enable=2'b10, s=shown[7:4]; BLANKx: enable=2'b00, s=s held.
//     disp_en=0 forces enable=2'b00 one cycle later; s, FSM, counter unaffected.
//   - Update: upd_ready = !pend_valid. On upd_valid&&upd_ready, upd_value goes
//     into pend and pend_valid is set next cycle. upd_valid with ready low is
//     ignored; the sender holds it.
//   - Frame boundary = cycle FSM enters SHOW0 (from BLANK1, or from SHOW1 when
//     BLANK_CYCLES=0). If pend_valid was set before that cycle, shown<=pend and
//     pend_valid clears. upd_ready rises on the next cycle. That SHOW0 already
//     shows the new value. frame_tick=1 on every frame-boundary cycle.
//   - Same-cycle accept and boundary: the value goes to pend and applies at the
//     NEXT boundary. No bypass into shown.
//   - Reset (any cycle, mid-frame too): state=SHOW0, counter=0, shown=8'h00,
//     pend_valid=0. Next cycle: enable=2'b01, s=4'h0, upd_ready=1, frame_tick=0.
//     The first frame_tick comes at the first SHOW0 entry after reset.
//   - enable never shows 2'b11, even for one cycle, in any state/transition.
// TESTING (DWELL_CYCLES=4, BLANK_CYCLES=1 unless stated)
//   - Reset then idle 30 cycles -> enable repeats 01x4,00x1,10x4,00x1;
//     frame_tick every 10 cycles; s=0 throughout.
//   - Send 8'hA5 mid-SHOW1 -> upd_ready low next cycle; next SHOW0 has s=5,
//     then SHOW1 has s=A; frame_tick on that SHOW0 entry; ready high after it.
//   - Send 8'h3C on the exact frame-boundary cycle -> current frame shows old
//     value; 8'h3C appears one frame (10 cycles) later.
//   - Send 8'h11 then hold upd_valid with 8'h22 while ready=0 -> 8'h22 accepted
//     only after the 8'h11 boundary; frames show 11, then 22; no value lost.
//   - Pulse reset during SHOW1 with a pending value -> pending dropped;
//     enable=01, s=0 next cycle; scan restarts from SHOW0.
//   - BLANK_CYCLES=0, disp_en toggled -> no 00 gaps while disp_en=1; enable=00
//     while disp_en=0; frame_tick period 8; assert enable!=2'b11 every cycle.

Source files
------------

// File: rtl/display_scan_ctrl_if.sv
// display_scan_ctrl_if
//   Bundles the update handshake and display outputs of display_scan_ctrl.
//   master : value sender / display consumer (drives upd_valid, upd_value, disp_en)
//   slave  : the scan controller (drives upd_ready, s, enable, frame_tick)
//   Signals:
//     upd_valid  - upd_value offered this cycle
//     upd_value  - new display value, [7:4] upper digit, [3:0] lower digit
//     upd_ready  - controller can accept a value (pending slot empty)
//     disp_en    - 0 blanks both digits; scanning continues
//     s          - nibble to the segment decoder
//     enable     - digit enables, one-hot or 2'b00
//     frame_tick - 1-cycle pulse when a new frame starts
interface display_scan_ctrl_if;
  logic       upd_valid;
  logic [7:0] upd_value;
  logic       upd_ready;
  logic       disp_en;
  logic [3:0] s;
  logic [1:0] enable;
  logic       frame_tick;

  modport master (
    output upd_valid, upd_value, disp_en,
    input  upd_ready, s, enable, frame_tick
  );

  modport slave (
    input  upd_valid, upd_value, disp_en,
    output upd_ready, s, enable, frame_tick
  );
endinterface

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl
//   Scan scheduler for a dual seven-segment display. Time-slices the lower
//   digit (value[3:0]) and upper digit (value[7:4]) with an optional blanking
//   gap between them. New values are taken through a valid/ready port into a
//   single pending slot and only become visible at a frame boundary (entry to
//   SHOW0), so a frame never mixes old and new digits.
//   Ports:
//     clk   - system clock, all logic on posedge
//     reset - synchronous, active-high
//     bus   - display_scan_ctrl_if.slave (update handshake + display outputs)
module display_scan_ctrl #(
  parameter int unsigned DWELL_CYCLES = 25000,
  parameter int unsigned BLANK_CYCLES = 250
) (
  input logic           clk,
  input logic           reset,
  display_scan_ctrl_if.slave bus
);

  localparam int unsigned MAXC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int unsigned CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYCLES == 0) ? 0 : BLANK_CYCLES - 1);

  typedef enum logic [1:0] {SHOW0, BLANK0, SHOW1, BLANK1} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    shown_q, shown_d;
  logic [7:0]    pend_q, pend_d;
  logic          pend_valid_q, pend_valid_d;
  logic [3:0]    s_q, s_d;
  logic [1:0]    enable_q, enable_d;
  logic          tick_q, tick_d;
  logic          boundary;
  logic [1:0]    en_raw;

  // Outputs are registered from the next-state values so that they line up
  // with state_q on the same cycle (SHOW0 already shows a freshly applied value).
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + CW'(1);
    shown_d      = shown_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    s_d          = s_q;
    en_raw       = 2'b00;

    unique case (state_q)
      SHOW0:  if (cnt_q == DWELL_LAST) state_d = (BLANK_CYCLES == 0) ? SHOW1 : BLANK0;
      BLANK0: if (cnt_q == BLANK_LAST) state_d = SHOW1;
      SHOW1:  if (cnt_q == DWELL_LAST) state_d = (BLANK_CYCLES == 0) ? SHOW0 : BLANK1;
      BLANK1: if (cnt_q == BLANK_LAST) state_d = SHOW0;
      default: state_d = SHOW0;
    endcase

    if (state_d != state_q) cnt_d = '0;

    boundary = (state_d == SHOW0) && (state_q != SHOW0);

    // Apply only a value that was already pending; a same-cycle accept waits
    // for the following boundary. The two branches are mutually exclusive.
    if (boundary && pend_valid_q) begin
      shown_d      = pend_q;
      pend_valid_d = 1'b0;
    end
    if (bus.upd_valid && !pend_valid_q) begin
      pend_d       = bus.upd_value;
      pend_valid_d = 1'b1;
    end

    unique case (state_d)
      SHOW0: begin en_raw = 2'b01; s_d = shown_d[3:0]; end
      SHOW1: begin en_raw = 2'b10; s_d = shown_d[7:4]; end
      default: en_raw = 2'b00;
    endcase

    enable_d = bus.disp_en ? en_raw : 2'b00;
    tick_d   = boundary;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= SHOW0;
      cnt_q        <= '0;
      shown_q      <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      s_q          <= '0;
      enable_q     <= 2'b01;
      tick_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shown_q      <= shown_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      s_q          <= s_d;
      enable_q     <= enable_d;
      tick_q       <= tick_d;
    end
  end

  assign bus.upd_ready  = !pend_valid_q;
  assign bus.s          = s_q;
  assign bus.enable     = enable_q;
  assign bus.frame_tick = tick_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
module tb_display_scan_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;
  display_scan_ctrl_if ifa ();
  display_scan_ctrl_if ifb ();

  display_scan_ctrl #(.DWELL_CYCLES(4), .BLANK_CYCLES(1)) dut_a (.clk(clk), .reset(rst_a), .bus(ifa.slave));
  display_scan_ctrl #(.DWELL_CYCLES(4), .BLANK_CYCLES(0)) dut_b (.clk(clk), .reset(rst_b), .bus(ifb.slave));

  int total = 0;
  int bad   = 0;

  // Reference model for dut_a: frame position from cycle count since reset.
  localparam int PER = 10;
  int         t;
  logic [7:0] m_shown, m_pend;
  logic       m_pv;
  logic [3:0] m_s;
  logic [1:0] m_en;
  logic       m_tick;

  // Advance one clock; model applies the rules using the inputs at that edge.
  task automatic step_a();
    int   p;
    logic pv_old;
    @(posedge clk);
    if (rst_a) begin
      t = 0; m_shown = 8'h00; m_pv = 1'b0; m_en = 2'b01; m_s = 4'h0; m_tick = 1'b0;
    end else begin
      t++;
      p = t % PER;
      pv_old = m_pv;
      if (p == 0 && pv_old) begin m_shown = m_pend; m_pv = 1'b0; end
      if (ifa.upd_valid && !pv_old) begin m_pend = ifa.upd_value; m_pv = 1'b1; end
      m_tick = (p == 0);
      if (p < 4)      begin m_en = 2'b01; m_s = m_shown[3:0]; end
      else if (p < 5)       m_en = 2'b00;
      else if (p < 9) begin m_en = 2'b10; m_s = m_shown[7:4]; end
      else                  m_en = 2'b00;
      if (!ifa.disp_en) m_en = 2'b00;
    end
    #1;
  endtask

  // enable must never be 2'b11 on either instance
  always @(negedge clk) begin
    if (rst_a === 1'b0) begin
      total++;
      if (ifa.enable === 2'b11) begin bad++; $display("FAIL onehot_a enable=%b required!=11", ifa.enable); end
    end
    if (rst_b === 1'b0) begin
      total++;
      if (ifb.enable === 2'b11) begin bad++; $display("FAIL onehot_b enable=%b required!=11", ifb.enable); end
    end
  end

  task automatic test_reset();
    rst_a = 1'b1;
    step_a();
    step_a();
    rst_a = 1'b0;
    total++;
    if (ifa.enable !== 2'b01) begin bad++; $display("FAIL reset_enable got=%b exp=01", ifa.enable); end
    total++;
    if (ifa.s !== 4'h0) begin bad++; $display("FAIL reset_s got=%h exp=0", ifa.s); end
    total++;
    if (ifa.upd_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", ifa.upd_ready); end
    total++;
    if (ifa.frame_tick !== 1'b0) begin bad++; $display("FAIL reset_tick got=%b exp=0", ifa.frame_tick); end
  endtask

  task automatic test_idle();
    int ticks = 0;
    for (int i = 0; i < 30; i++) begin
      step_a();
      if (ifa.frame_tick === 1'b1) ticks++;
      total++;
      if ({ifa.enable, ifa.s, ifa.frame_tick, ifa.upd_ready} !== {m_en, m_s, m_tick, !m_pv}) begin
        bad++; $display("FAIL idle t=%0d got en=%b s=%h tk=%b rdy=%b exp en=%b s=%h tk=%b rdy=%b",
                        t, ifa.enable, ifa.s, ifa.frame_tick, ifa.upd_ready, m_en, m_s, m_tick, !m_pv);
      end
    end
    total++;
    if (ticks != 3) begin bad++; $display("FAIL idle_tick_count got=%0d exp=3", ticks); end
  endtask

  task automatic test_send_a5();
    int n = 0;
    while (t % PER != 6 && n < 20) begin step_a(); n++; end
    ifa.upd_valid = 1'b1; ifa.upd_value = 8'hA5;
    step_a();
    ifa.upd_valid = 1'b0;
    total++;
    if (ifa.upd_ready !== 1'b0) begin bad++; $display("FAIL a5_ready_low got=%b exp=0", ifa.upd_ready); end
    for (int i = 0; i < 14; i++) begin
      step_a();
      total++;
      if ({ifa.enable, ifa.s, ifa.frame_tick, ifa.upd_ready} !== {m_en, m_s, m_tick, !m_pv}) begin
        bad++; $display("FAIL a5 t=%0d got en=%b s=%h tk=%b rdy=%b exp en=%b s=%h tk=%b rdy=%b",
                        t, ifa.enable, ifa.s, ifa.frame_tick, ifa.upd_ready, m_en, m_s, m_tick, !m_pv);
      end
      if (t % PER == 0) begin
        total++;
        if (ifa.s !== 4'h5 || ifa.frame_tick !== 1'b1 || ifa.upd_ready !== 1'b1) begin
          bad++; $display("FAIL a5_show0 got s=%h tk=%b rdy=%b exp s=5 tk=1 rdy=1", ifa.s, ifa.frame_tick, ifa.upd_ready);
        end
      end
      if (t % PER == 5) begin
        total++;
        if (ifa.s !== 4'hA) begin bad++; $display("FAIL a5_show1 got s=%h exp=a", ifa.s); end
      end
    end
  endtask

  task automatic test_boundary_3c();
    int n = 0;
    while (t % PER != 9 && n < 20) begin step_a(); n++; end
    ifa.upd_valid = 1'b1; ifa.upd_value = 8'h3C;
    step_a();
    ifa.upd_valid = 1'b0;
    total++;
    if (ifa.s !== 4'h5 || ifa.frame_tick !== 1'b1) begin
      bad++; $display("FAIL b3c_old_frame got s=%h tk=%b exp s=5 tk=1", ifa.s, ifa.frame_tick);
    end
    for (int i = 0; i < 10; i++) begin
      step_a();
      total++;
      if ({ifa.enable, ifa.s, ifa.frame_tick, ifa.upd_ready} !== {m_en, m_s, m_tick, !m_pv}) begin
        bad++; $display("FAIL b3c t=%0d got en=%b s=%h tk=%b exp en=%b s=%h tk=%b",
                        t, ifa.enable, ifa.s, ifa.frame_tick, m_en, m_s, m_tick);
      end
    end
    total++;
    if (ifa.s !== 4'hC || ifa.frame_tick !== 1'b1) begin
      bad++; $display("FAIL b3c_new_frame got s=%h tk=%b exp s=c tk=1", ifa.s, ifa.frame_tick);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] seen[$];
    logic       rdy;
    int         n = 0;
    while (ifa.upd_ready !== 1'b1 && n < 30) begin step_a(); n++; end
    ifa.upd_valid = 1'b1; ifa.upd_value = 8'h11;
    step_a();
    ifa.upd_value = 8'h22;
    n = 0;
    forever begin
      rdy = ifa.upd_ready;
      step_a();
      n++;
      if (ifa.frame_tick === 1'b1) seen.push_back(ifa.s);
      total++;
      if ({ifa.enable, ifa.s, ifa.frame_tick, ifa.upd_ready} !== {m_en, m_s, m_tick, !m_pv}) begin
        bad++; $display("FAIL b2b_hold t=%0d got en=%b s=%h rdy=%b exp en=%b s=%h rdy=%b",
                        t, ifa.enable, ifa.s, ifa.upd_ready, m_en, m_s, !m_pv);
      end
      if (rdy === 1'b1) break;
      if (n >= 30) begin
        total++; bad++; $display("FAIL b2b_timeout got=not_accepted exp=accepted");
        break;
      end
    end
    ifa.upd_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step_a();
      if (ifa.frame_tick === 1'b1) seen.push_back(ifa.s);
    end
    total++;
    if (seen.size() < 2) begin
      bad++; $display("FAIL b2b_frames got=%0d exp>=2", seen.size());
    end else if (seen[0] !== 4'h1 || seen[1] !== 4'h2) begin
      bad++; $display("FAIL b2b_order got=%h,%h exp=1,2", seen[0], seen[1]);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    while (!(t % PER == 5 && !m_pv) && n < 40) begin step_a(); n++; end
    ifa.upd_valid = 1'b1; ifa.upd_value = 8'h77;
    step_a();
    ifa.upd_valid = 1'b0;
    step_a();
    total++;
    if (ifa.upd_ready !== 1'b0 || ifa.enable !== 2'b10) begin
      bad++; $display("FAIL rmid_pre got rdy=%b en=%b exp rdy=0 en=10", ifa.upd_ready, ifa.enable);
    end
    rst_a = 1'b1;
    step_a();
    rst_a = 1'b0;
    total++;
    if ({ifa.enable, ifa.s, ifa.upd_ready, ifa.frame_tick} !== {2'b01, 4'h0, 1'b1, 1'b0}) begin
      bad++; $display("FAIL rmid_after got en=%b s=%h rdy=%b tk=%b exp en=01 s=0 rdy=1 tk=0",
                      ifa.enable, ifa.s, ifa.upd_ready, ifa.frame_tick);
    end
    for (int i = 0; i < 12; i++) begin
      step_a();
      total++;
      if ({ifa.enable, ifa.s, ifa.frame_tick} !== {m_en, 4'h0, m_tick}) begin
        bad++; $display("FAIL rmid_restart t=%0d got en=%b s=%h tk=%b exp en=%b s=0 tk=%b",
                        t, ifa.enable, ifa.s, ifa.frame_tick, m_en, m_tick);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      ifa.upd_valid = ($urandom_range(0, 3) == 0);
      ifa.upd_value = 8'($urandom);
      ifa.disp_en   = ($urandom_range(0, 4) != 0);
      step_a();
      total++;
      if ({ifa.enable, ifa.s, ifa.frame_tick, ifa.upd_ready} !== {m_en, m_s, m_tick, !m_pv}) begin
        bad++; $display("FAIL rand t=%0d got en=%b s=%h tk=%b rdy=%b exp en=%b s=%h tk=%b rdy=%b",
                        t, ifa.enable, ifa.s, ifa.frame_tick, ifa.upd_ready, m_en, m_s, m_tick, !m_pv);
      end
    end
    ifa.upd_valid = 1'b0;
    ifa.disp_en   = 1'b1;
  endtask

  task automatic test_no_blank();
    int       tb_t, p, ticks;
    logic     en_at_edge;
    logic [1:0] exp_en;
    logic       exp_tk;
    ticks = 0;
    rst_b = 1'b1;
    @(posedge clk); #1;
    rst_b = 1'b0;
    tb_t = 0;
    for (int i = 0; i < 40; i++) begin
      ifb.disp_en = ($urandom_range(0, 2) != 0);
      en_at_edge = ifb.disp_en;
      @(posedge clk); #1;
      tb_t++;
      p = tb_t % 8;
      exp_en = !en_at_edge ? 2'b00 : (p < 4) ? 2'b01 : 2'b10;
      exp_tk = (p == 0);
      if (ifb.frame_tick === 1'b1) ticks++;
      total++;
      if ({ifb.enable, ifb.frame_tick} !== {exp_en, exp_tk}) begin
        bad++; $display("FAIL noblank t=%0d got en=%b tk=%b exp en=%b tk=%b",
                        tb_t, ifb.enable, ifb.frame_tick, exp_en, exp_tk);
      end
    end
    total++;
    if (ticks != 5) begin bad++; $display("FAIL noblank_ticks got=%0d exp=5", ticks); end
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    ifa.upd_valid = 1'b0; ifa.upd_value = 8'h00; ifa.disp_en = 1'b1;
    ifb.upd_valid = 1'b0; ifb.upd_value = 8'h00; ifb.disp_en = 1'b1;
    t = 0; m_shown = '0; m_pend = '0; m_pv = 1'b0; m_s = '0; m_en = 2'b01; m_tick = 1'b0;
    #1;
    test_reset();
    test_idle();
    test_send_a5();
    test_boundary_3c();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_no_blank();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
